countdown_timer: RTL and testbench

Down-counting minutes:seconds timer: the reverse-direction companion to the up-counting `digital_time` stopwatch. It loads a preset, counts down once per second while enabled and flags expiry at 00:00. It drives the same display and alarm path as the stopwatch and is clocked from the same 50 MHz system clock.

---
 rtl/timer_pkg.sv | 19 +
 rtl/tick_prescaler.sv | 36 +++
 rtl/countdown_timer.sv | 114 +++++++++++
 tb/tb_countdown_timer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and limits for the minutes:seconds countdown timer.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } timer_state_t;

    localparam logic [7:0] MAX_MIN = 8'd99;
    localparam logic [7:0] MAX_SEC = 8'd59;

    // Saturate a binary preset to an upper limit.
    function automatic logic [7:0] clamp8(input logic [7:0] v, input logic [7:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock down to a one-cycle tick every TICK_DIV enabled cycles.
// Holding en low freezes the count, so a partial period survives a pause.
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int W = $clog2(TICK_DIV);
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt;

    // Tick is combinational so the consumer acts on the same edge that rolls the count over.
    assign tick = en && (cnt == LAST);

    // Clear wins over counting; otherwise count modulo TICK_DIV while enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Down-counting mm:ss timer with preset load, pause/resume and expiry flag.
// All outputs are registered; dbg_state mirrors the FSM state for checkers.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [7:0]   load_min,
    input  logic [7:0]   load_sec,
    input  logic         start,
    output logic [7:0]   min,
    output logic [7:0]   sec,
    output logic         running,
    output logic         done,
    output logic         expired,
    output timer_state_t dbg_state
);

    timer_state_t state;
    logic         tick;
    logic [7:0]   dec_min;
    logic [7:0]   dec_sec;
    logic         dec_zero;

    assign dbg_state = state;

    // Prescaler only advances in RUN; a load restarts the second from zero.
    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .en  (state == RUN),
        .clr (load),
        .tick(tick)
    );

    // Next count value after one second elapses, borrowing from minutes at :00.
    always_comb begin
        dec_min = min;
        dec_sec = sec;
        if (sec != 8'd0) begin
            dec_sec = sec - 8'd1;
        end else if (min != 8'd0) begin
            dec_min = min - 8'd1;
            dec_sec = MAX_SEC;
        end
        dec_zero = (dec_min == 8'd0) && (dec_sec == 8'd0);
    end

    // FSM and count registers; load overrides everything, including a same-cycle tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            min     <= 8'd0;
            sec     <= 8'd0;
            running <= 1'b0;
            done    <= 1'b0;
            expired <= 1'b0;
        end else if (load) begin
            state   <= IDLE;
            min     <= clamp8(load_min, MAX_MIN);
            sec     <= clamp8(load_sec, MAX_SEC);
            running <= 1'b0;
            done    <= 1'b0;
            expired <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && ((min != 8'd0) || (sec != 8'd0))) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (tick) begin
                        min <= dec_min;
                        sec <= dec_sec;
                        if (dec_zero) begin
                            state   <= EXPIRED;
                            running <= 1'b0;
                            done    <= 1'b1;
                            expired <= 1'b1;
                        end else if (!start) begin
                            state   <= PAUSE;
                            running <= 1'b0;
                        end
                    end else if (!start) begin
                        state   <= PAUSE;
                        running <= 1'b0;
                    end
                end
                PAUSE: begin
                    if (start) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                EXPIRED: begin
                    expired <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with TICK_DIV=4: a vector table for
// single-cycle behaviour plus hand sequences for multi-cycle corner cases.
module tb_countdown_timer;
    import timer_pkg::*;

    localparam int TD = 4;

    logic         clk;
    logic         rst;
    logic         load;
    logic [7:0]   load_min;
    logic [7:0]   load_sec;
    logic         start;
    logic [7:0]   min;
    logic [7:0]   sec;
    logic         running;
    logic         done;
    logic         expired;
    timer_state_t dbg_state;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic         ld;
        logic [7:0]   lm;
        logic [7:0]   ls;
        logic         st;
        logic [7:0]   em;
        logic [7:0]   es;
        logic         er;
        logic         ed;
        logic         ee;
        timer_state_t est;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    countdown_timer #(.TICK_DIV(TD)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_min (load_min),
        .load_sec (load_sec),
        .start    (start),
        .min      (min),
        .sec      (sec),
        .running  (running),
        .done     (done),
        .expired  (expired),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic ld, input logic [7:0] lm, input logic [7:0] ls,
                                input logic st, input logic [7:0] em, input logic [7:0] es,
                                input logic er, input logic ed, input logic ee,
                                input timer_state_t est);
        vec_t v;
        v.ld = ld; v.lm = lm; v.ls = ls; v.st = st;
        v.em = em; v.es = es; v.er = er; v.ed = ed; v.ee = ee; v.est = est;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic [7:0] em, input logic [7:0] es,
                           input logic er, input logic ed, input logic ee, input timer_state_t est);
        chk({nm, ".min"},     32'(min),       32'(em));
        chk({nm, ".sec"},     32'(sec),       32'(es));
        chk({nm, ".running"}, 32'(running),   32'(er));
        chk({nm, ".done"},    32'(done),      32'(ed));
        chk({nm, ".expired"}, 32'(expired),   32'(ee));
        chk({nm, ".state"},   32'(dbg_state), 32'(est));
    endtask

    // driver: set inputs, then let one edge happen and sample 1 time unit later
    task automatic drive(input logic ld, input logic [7:0] lm, input logic [7:0] ls, input logic st);
        load = ld; load_min = lm; load_sec = ls; start = st;
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] lm, input logic [7:0] ls);
        drive(1'b1, lm, ls, 1'b0);
    endtask

    initial begin
        load = 1'b0; load_min = 8'd0; load_sec = 8'd0; start = 1'b0;
        rst = 1'b1;

        vecs[0]  = mk(1, 8'd150, 8'd75, 0, 8'd99, 8'd59, 0, 0, 0, IDLE);
        vecs[1]  = mk(1, 8'd0,   8'd0,  1, 8'd0,  8'd0,  0, 0, 0, IDLE);
        vecs[2]  = mk(0, 8'd0,   8'd0,  1, 8'd0,  8'd0,  0, 0, 0, IDLE);
        vecs[3]  = mk(0, 8'd0,   8'd0,  1, 8'd0,  8'd0,  0, 0, 0, IDLE);
        vecs[4]  = mk(1, 8'd1,   8'd0,  0, 8'd1,  8'd0,  0, 0, 0, IDLE);
        vecs[5]  = mk(0, 8'd0,   8'd0,  1, 8'd1,  8'd0,  1, 0, 0, RUN);
        vecs[6]  = mk(0, 8'd0,   8'd0,  1, 8'd1,  8'd0,  1, 0, 0, RUN);
        vecs[7]  = mk(0, 8'd0,   8'd0,  1, 8'd1,  8'd0,  1, 0, 0, RUN);
        vecs[8]  = mk(0, 8'd0,   8'd0,  1, 8'd1,  8'd0,  1, 0, 0, RUN);
        vecs[9]  = mk(0, 8'd0,   8'd0,  1, 8'd0,  8'd59, 1, 0, 0, RUN);
        vecs[10] = mk(1, 8'd100, 8'd60, 1, 8'd99, 8'd59, 0, 0, 0, IDLE);
        vecs[11] = mk(1, 8'd99,  8'd59, 0, 8'd99, 8'd59, 0, 0, 0, IDLE);
        vecs[12] = mk(1, 8'd0,   8'd60, 0, 8'd0,  8'd59, 0, 0, 0, IDLE);

        repeat (2) @(posedge clk);
        #1;
        chk_all("reset_hold", 8'd0, 8'd0, 0, 0, 0, IDLE);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        chk_all("after_reset", 8'd0, 8'd0, 0, 0, 0, IDLE);

        // table: clamp, zero preset with start, minute borrow
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].ld, vecs[i].lm, vecs[i].ls, vecs[i].st);
            chk_all($sformatf("vec%0d", i), vecs[i].em, vecs[i].es,
                    vecs[i].er, vecs[i].ed, vecs[i].ee, vecs[i].est);
        end

        // 00:03 runs to expiry in 12 RUN cycles; start then ignored
        do_load(8'd0, 8'd3);
        drive(0, 0, 0, 1);
        chk_all("exp_enter_run", 8'd0, 8'd3, 1, 0, 0, RUN);
        for (int rc = 1; rc <= 12; rc++) begin
            drive(0, 0, 0, 1);
            if (rc < 12) begin
                chk($sformatf("exp_rc%0d.sec", rc), 32'(sec), 32'(3 - rc / TD));
                chk($sformatf("exp_rc%0d.done", rc), 32'(done), 32'd0);
            end
        end
        chk_all("exp_done", 8'd0, 8'd0, 0, 1, 1, EXPIRED);
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, k[0]);
            chk_all($sformatf("exp_hold%0d", k), 8'd0, 8'd0, 0, 0, 1, EXPIRED);
        end

        // 00:02 with a 10-cycle pause after 2 RUN cycles keeps the partial second
        do_load(8'd0, 8'd2);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 0);
        chk_all("pause_enter", 8'd0, 8'd2, 0, 0, 0, PAUSE);
        repeat (10) drive(0, 0, 0, 0);
        chk_all("pause_hold", 8'd0, 8'd2, 0, 0, 0, PAUSE);
        drive(0, 0, 0, 1);
        chk_all("resume", 8'd0, 8'd2, 1, 0, 0, RUN);
        drive(0, 0, 0, 1);
        chk_all("resume_rc3", 8'd0, 8'd2, 1, 0, 0, RUN);
        drive(0, 0, 0, 1);
        chk_all("resume_rc4", 8'd0, 8'd1, 1, 0, 0, RUN);
        repeat (3) drive(0, 0, 0, 1);
        chk_all("resume_rc7", 8'd0, 8'd1, 1, 0, 0, RUN);
        drive(0, 0, 0, 1);
        chk_all("resume_rc8", 8'd0, 8'd0, 0, 1, 1, EXPIRED);

        // start falling on a tick still decrements, then pauses
        do_load(8'd0, 8'd5);
        drive(0, 0, 0, 1);
        repeat (3) drive(0, 0, 0, 1);
        drive(0, 0, 0, 0);
        chk_all("tick_stop", 8'd0, 8'd4, 0, 0, 0, PAUSE);

        // load colliding with the final tick discards it
        do_load(8'd0, 8'd1);
        drive(0, 0, 0, 1);
        repeat (3) drive(0, 0, 0, 1);
        chk_all("coll_pre", 8'd0, 8'd1, 1, 0, 0, RUN);
        drive(1, 8'd0, 8'd5, 1);
        chk_all("coll_load", 8'd0, 8'd5, 0, 0, 0, IDLE);
        drive(0, 0, 0, 1);
        chk_all("coll_next", 8'd0, 8'd5, 1, 0, 0, RUN);

        // asynchronous reset mid-RUN, checked before the next edge
        do_load(8'd0, 8'd9);
        drive(0, 0, 0, 1);
        repeat (2) drive(0, 0, 0, 1);
        #2 rst = 1'b1;
        #1;
        chk_all("async_rst", 8'd0, 8'd0, 0, 0, 0, IDLE);
        #3 rst = 1'b0;
        start = 1'b0;

        // after reset the prescaler starts from zero: 00:01 expires in exactly 4 RUN cycles
        do_load(8'd0, 8'd1);
        drive(0, 0, 0, 1);
        repeat (3) drive(0, 0, 0, 1);
        chk_all("post_rst_rc3", 8'd0, 8'd1, 1, 0, 0, RUN);
        drive(0, 0, 0, 1);
        chk_all("post_rst_rc4", 8'd0, 8'd0, 0, 1, 1, EXPIRED);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // global watchdog so the bench always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
